// File: rtl/ula_controlador.sv
// ula_controlador: valid/ready command initiator driving an external 4-bit ULA from a 4x4 register file.
// Optional zero/carry status outputs (flag_z, flag_c) are built when ULA_CTRL_FLAGS_EN is defined.
module ula_controlador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_ld,
    input  logic [WIDTH-1:0] cmd_imm,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_rd,
    input  logic [1:0]       cmd_ra,
    input  logic [1:0]       cmd_rb,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [2:0]       ula_sel,
    input  logic [WIDTH-1:0] ula_res,
    output logic             done,
    output logic [WIDTH-1:0] done_res,
    input  logic [1:0]       dbg_idx,
    output logic [WIDTH-1:0] dbg_data
`ifdef ULA_CTRL_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_c
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic             wr_en_s;
    logic [WIDTH-1:0] wr_val_s;

    logic             ld_r;
    logic [WIDTH-1:0] imm_r;
    logic [1:0]       rd_r;
    logic [WIDTH-1:0] rf_r [4];

    // Next-state decode plus writeback value selection
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        wr_en_s      = 1'b0;
        wr_val_s     = ula_res;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                wr_en_s      = 1'b1;
                state_next_s = ST_DONE;
                if (ld_r) begin
                    wr_val_s = imm_r;
                end else begin
                    wr_val_s = ula_res;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command latch, ULA drive, register-file writeback and completion strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            done_res  <= {WIDTH{1'b0}};
            ula_a     <= {WIDTH{1'b0}};
            ula_b     <= {WIDTH{1'b0}};
            ula_sel   <= 3'b000;
            ld_r      <= 1'b0;
            imm_r     <= {WIDTH{1'b0}};
            rd_r      <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                rf_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            // Ready is registered so it reflects the state being entered
            cmd_ready <= (state_next_s == ST_IDLE);
            done      <= wr_en_s;
            if (accept_s) begin
                ld_r    <= cmd_ld;
                imm_r   <= cmd_imm;
                rd_r    <= cmd_rd;
                ula_a   <= rf_r[cmd_ra];
                ula_b   <= rf_r[cmd_rb];
                ula_sel <= cmd_op;
            end
            if (wr_en_s) begin
                rf_r[rd_r] <= wr_val_s;
                done_res   <= wr_val_s;
            end
        end
    end

    assign dbg_data = rf_r[dbg_idx];

`ifdef ULA_CTRL_FLAGS_EN
    logic [WIDTH:0] opa_r;
    logic [WIDTH:0] opb_r;

    // Carry for ADD, borrow for SUB, zero for every other selector
    function automatic logic carry_flag(input logic [2:0] op, input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic [WIDTH:0] sum_v;
        sum_v = a + b;
        case (op)
            3'b100:  carry_flag = sum_v[WIDTH];
            3'b101:  carry_flag = (a < b);
            default: carry_flag = 1'b0;
        endcase
    endfunction

    // Operand copies and status flags, updated alongside done_res
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_r  <= {(WIDTH+1){1'b0}};
            opb_r  <= {(WIDTH+1){1'b0}};
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (accept_s) begin
                opa_r <= {1'b0, rf_r[cmd_ra]};
                opb_r <= {1'b0, rf_r[cmd_rb]};
            end
            if (wr_en_s) begin
                flag_z <= (wr_val_s == {WIDTH{1'b0}});
                if (ld_r) begin
                    flag_c <= 1'b0;
                end else begin
                    flag_c <= carry_flag(ula_sel, opa_r, opb_r);
                end
            end
        end
    end
`endif

endmodule
